// File: rtl/instr_cache_pkg.sv
// Shared types and field-width helpers for the direct-mapped instruction cache.
//   state_e    : refill FSM encoding (idle lookup, word-by-word refill, bubble)
//   log2_of    : bit width needed to index n entries (n a power of 2)
//   tag_width  : PC tag bits left after the word-offset, line-offset and index fields
package instr_cache_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRefill,
    StDone
  } state_e;

  function automatic int unsigned log2_of(input int unsigned n);
    return $clog2(n);
  endfunction

  function automatic int unsigned tag_width(input int unsigned lines, input int unsigned words);
    return 30 - log2_of(words) - log2_of(lines);
  endfunction

endpackage

// File: rtl/instr_cache_if.sv
// Fetch-port and refill-bus signals of the instruction cache.
//   PC/Flush/Instr/StallF       : core fetch side
//   mem_req/mem_addr/mem_ack/
//   mem_rdata                   : backing instruction memory side
// Modports: slave = the cache itself, master = core plus backing memory (environment).
interface instr_cache_if;
  logic [31:0] PC;
  logic [31:0] Instr;
  logic        StallF;
  logic        Flush;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport slave (
    input  PC, Flush, mem_ack, mem_rdata,
    output Instr, StallF, mem_req, mem_addr
  );

  modport master (
    output PC, Flush, mem_ack, mem_rdata,
    input  Instr, StallF, mem_req, mem_addr
  );
endinterface

// File: rtl/instr_cache_array.sv
// Tag/valid/data storage for the instruction cache.
//   clk, reset          : clock, async active-low reset (clears valid bits only)
//   rd_idx, rd_off      : async read port -> rd_valid, rd_tag, rd_data
//   wr_idx              : line addressed by all write-side controls
//   wr_en/wr_word/
//   wr_data             : sync data word write
//   set_tag/wr_tag      : sync tag write
//   set_valid/clr_valid : set or clear valid[wr_idx]
//   inv_all             : clear every valid bit (overrides set_valid)
module instr_cache_array
  import instr_cache_pkg::*;
#(
  parameter int unsigned LINES = 16,
  parameter int unsigned WORDS = 4
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [log2_of(LINES)-1:0]            rd_idx,
  input  logic [log2_of(WORDS)-1:0]            rd_off,
  output logic                                 rd_valid,
  output logic [tag_width(LINES, WORDS)-1:0]   rd_tag,
  output logic [31:0]                          rd_data,
  input  logic [log2_of(LINES)-1:0]            wr_idx,
  input  logic                                 wr_en,
  input  logic [log2_of(WORDS)-1:0]            wr_word,
  input  logic [31:0]                          wr_data,
  input  logic                                 set_tag,
  input  logic [tag_width(LINES, WORDS)-1:0]   wr_tag,
  input  logic                                 set_valid,
  input  logic                                 clr_valid,
  input  logic                                 inv_all
);

  localparam int unsigned TagW = tag_width(LINES, WORDS);

  logic [LINES-1:0] valid_q, valid_d;
  logic [TagW-1:0]  tag_q  [LINES];
  logic [31:0]      data_q [LINES][WORDS];

  always_comb begin
    valid_d = valid_q;
    if (clr_valid) valid_d[wr_idx] = 1'b0;
    if (set_valid) valid_d[wr_idx] = 1'b1;
    if (inv_all)   valid_d = '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) valid_q <= '0;
    else        valid_q <= valid_d;
  end

  always_ff @(posedge clk) begin
    if (set_tag) tag_q[wr_idx] <= wr_tag;
  end

  always_ff @(posedge clk) begin
    if (wr_en) data_q[wr_idx][wr_word] <= wr_data;
  end

  assign rd_valid = valid_q[rd_idx];
  assign rd_tag   = tag_q[rd_idx];
  assign rd_data  = data_q[rd_idx][rd_off];

endmodule

// File: rtl/instr_cache.sv
// Direct-mapped read-only instruction cache.
//   clk, reset : clock, async active-low reset
//   bus        : instr_cache_if.slave -- fetch port (PC, Flush -> Instr, StallF) and
//                refill port (mem_req, mem_addr -> mem_ack, mem_rdata)
// Hits return in the fetch cycle; a miss stalls fetch, refills the whole line one word
// per ack, then spends one bubble cycle before the lookup is retried.
module instr_cache
  import instr_cache_pkg::*;
#(
  parameter int unsigned LINES = 16,
  parameter int unsigned WORDS = 4
) (
  input logic           clk,
  input logic           reset,
  instr_cache_if.slave  bus
);

  localparam int unsigned OffW  = log2_of(WORDS);
  localparam int unsigned IdxW  = log2_of(LINES);
  localparam int unsigned TagW  = tag_width(LINES, WORDS);
  localparam int unsigned LineW = TagW + IdxW;

  logic [OffW-1:0]  pc_off;
  logic [IdxW-1:0]  pc_idx;
  logic [TagW-1:0]  pc_tag;
  logic [LineW-1:0] pc_line;
  logic             unused_pc_bits;

  assign pc_off         = bus.PC[OffW+1:2];
  assign pc_idx         = bus.PC[OffW+2 +: IdxW];
  assign pc_tag         = bus.PC[31 -: TagW];
  assign pc_line        = bus.PC[31 -: LineW];
  assign unused_pc_bits = ^bus.PC[1:0];

  state_e           state_q, state_d;
  logic [LineW-1:0] line_q, line_d;   // {tag, idx} of the line being refilled
  logic [OffW-1:0]  cnt_q, cnt_d;
  logic             flush_pend_q, flush_pend_d;

  logic             rd_valid;
  logic [TagW-1:0]  rd_tag;
  logic [31:0]      rd_data;
  logic [IdxW-1:0]  wr_idx;
  logic             wr_en, set_tag, set_valid, clr_valid, inv_all, hit;

  instr_cache_array #(
    .LINES (LINES),
    .WORDS (WORDS)
  ) u_array (
    .clk       (clk),
    .reset     (reset),
    .rd_idx    (pc_idx),
    .rd_off    (pc_off),
    .rd_valid  (rd_valid),
    .rd_tag    (rd_tag),
    .rd_data   (rd_data),
    .wr_idx    (wr_idx),
    .wr_en     (wr_en),
    .wr_word   (cnt_q),
    .wr_data   (bus.mem_rdata),
    .set_tag   (set_tag),
    .wr_tag    (line_q[LineW-1 -: TagW]),
    .set_valid (set_valid),
    .clr_valid (clr_valid),
    .inv_all   (inv_all)
  );

  always_comb begin
    state_d      = state_q;
    line_d       = line_q;
    cnt_d        = cnt_q;
    flush_pend_d = flush_pend_q;
    wr_idx       = line_q[IdxW-1:0];
    wr_en        = 1'b0;
    set_tag      = 1'b0;
    set_valid    = 1'b0;
    clr_valid    = 1'b0;
    inv_all      = bus.Flush;
    hit          = 1'b0;
    bus.Instr    = '0;
    bus.StallF   = 1'b1;
    bus.mem_req  = 1'b0;
    bus.mem_addr = '0;

    unique case (state_q)
      StIdle: begin
        // A flush in the lookup cycle forces a miss so the line is refetched.
        hit = rd_valid && (rd_tag == pc_tag) && !bus.Flush;
        if (hit) begin
          bus.Instr  = rd_data;
          bus.StallF = 1'b0;
        end else begin
          line_d    = pc_line;
          cnt_d     = '0;
          wr_idx    = pc_idx;
          clr_valid = 1'b1;
          state_d   = StRefill;
        end
      end
      StRefill: begin
        bus.mem_req  = 1'b1;
        bus.mem_addr = {line_q, cnt_q, 2'b00};
        if (bus.Flush) flush_pend_d = 1'b1;
        if (bus.mem_ack) begin
          wr_en = 1'b1;
          cnt_d = cnt_q + OffW'(1);
          if (cnt_q == OffW'(WORDS - 1)) begin
            set_tag   = 1'b1;
            // A flush seen at any point of this refill leaves the new line invalid.
            set_valid = !(flush_pend_q || bus.Flush);
            state_d   = StDone;
          end
        end
      end
      StDone: begin
        flush_pend_d = 1'b0;
        state_d      = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      line_q       <= '0;
      cnt_q        <= '0;
      flush_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      line_q       <= line_d;
      cnt_q        <= cnt_d;
      flush_pend_q <= flush_pend_d;
    end
  end

endmodule
